// File: rtl/corr_search_scheduler.sv
// Scans a rectangular grid of candidate start positions once per captured frame,
// driving the correlation engine and keeping the lowest score and its coordinates.
module corr_search_scheduler #(
    parameter int unsigned X_MIN   = 0,
    parameter int unsigned X_MAX   = 600,
    parameter int unsigned Y_MIN   = 0,
    parameter int unsigned Y_MAX   = 440,
    parameter int unsigned STEP    = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFrameDone,
    input  logic        iCorrFinished,
    input  logic [31:0] iCorrScore,
    output logic [12:0] oXstart,
    output logic [12:0] oYstart,
    output logic        oCorrStart,
    output logic [12:0] oXresult,
    output logic [12:0] oYresult,
    output logic [31:0] oBestScore,
    output logic [15:0] oPosCount,
    output logic        oBusy,
    output logic        oFinished,
    output logic        oTimeout
);

    localparam logic [12:0] XMin     = 13'(X_MIN);
    localparam logic [12:0] YMin     = 13'(Y_MIN);
    localparam logic [13:0] XMax     = 14'(X_MAX);
    localparam logic [13:0] YMax     = 14'(Y_MAX);
    localparam logic [13:0] Step     = 14'(STEP);
    // Counter value in the last WAIT cycle before a position is abandoned.
    localparam logic [31:0] WaitLast = 32'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StAdvance,
        StDone
    } state_e;

    state_e      state_q;
    logic        frame_q;
    logic        start;
    logic [31:0] wait_cnt_q;
    logic [31:0] score_q;
    logic [13:0] x_next;
    logic [13:0] y_next;

    assign start  = iFrameDone & ~frame_q;
    assign x_next = {1'b0, oXstart} + Step;
    assign y_next = {1'b0, oYstart} + Step;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= StIdle;
            frame_q    <= 1'b0;
            wait_cnt_q <= '0;
            score_q    <= '1;
            oXstart    <= XMin;
            oYstart    <= YMin;
            oCorrStart <= 1'b0;
            oXresult   <= '0;
            oYresult   <= '0;
            oBestScore <= '1;
            oPosCount  <= '0;
            oBusy      <= 1'b0;
            oFinished  <= 1'b0;
            oTimeout   <= 1'b0;
        end else begin
            frame_q    <= iFrameDone;
            oCorrStart <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        oXstart    <= XMin;
                        oYstart    <= YMin;
                        oBestScore <= '1;
                        oXresult   <= '0;
                        oYresult   <= '0;
                        oPosCount  <= '0;
                        oTimeout   <= 1'b0;
                        oFinished  <= 1'b0;
                        oBusy      <= 1'b1;
                        state_q    <= StLaunch;
                    end
                end
                StLaunch: begin
                    // Finished flag here still belongs to the previous position.
                    oCorrStart <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (iCorrFinished) begin
                        score_q <= iCorrScore;
                        state_q <= StAdvance;
                    end else if (wait_cnt_q == WaitLast) begin
                        oTimeout <= 1'b1;
                        score_q  <= '1;
                        state_q  <= StAdvance;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                StAdvance: begin
                    if (oPosCount != 16'hFFFF) begin
                        oPosCount <= oPosCount + 16'd1;
                    end
                    // Strict compare keeps the earliest of equal scores.
                    if (score_q < oBestScore) begin
                        oBestScore <= score_q;
                        oXresult   <= oXstart;
                        oYresult   <= oYstart;
                    end
                    if (x_next > XMax) begin
                        oXstart <= XMin;
                        if (y_next > YMax) begin
                            state_q <= StDone;
                        end else begin
                            oYstart <= y_next[12:0];
                            state_q <= StLaunch;
                        end
                    end else begin
                        oXstart <= x_next[12:0];
                        state_q <= StLaunch;
                    end
                end
                StDone: begin
                    oBusy     <= 1'b0;
                    oFinished <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
